// File: rtl/ysyx_22040759_fwd_scoreboard_pkg.sv
// Shared select encodings and FSM state type for the EX-stage forwarding/hazard unit.
package ysyx_22040759_fwd_scoreboard_pkg;
  localparam int FWD_SEL_RF = 0;

  // Long-latency completion bus sits one past the last pipeline producer select.
  function automatic int fwdSelLw(input int numFwd);
    return numFwd + 1;
  endfunction

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } fsmStateT;
endpackage

// File: rtl/ysyx_22040759_fwd_scoreboard_if.sv
// Consumer/producer/long-latency bus between the pipeline (master) and the forwarding unit (slave).
interface ysyx_22040759_fwd_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 3,
  parameter int AW      = 5
);
  localparam int SEL_W = $clog2(NUM_FWD + 2);
  localparam int NREG  = 2 ** AW;

  logic                             src_valid_i;
  logic [NUM_SRC-1:0]               src_used_i;
  logic [NUM_SRC-1:0][AW-1:0]       src_addr_i;
  logic [NUM_FWD-1:0]               stg_valid_i;
  logic [NUM_FWD-1:0]               stg_wen_i;
  logic [NUM_FWD-1:0][AW-1:0]       stg_rd_i;
  logic [NUM_FWD-1:0]               stg_ready_i;
  logic                             lw_iss_v_i;
  logic [AW-1:0]                    lw_iss_rd_i;
  logic                             lw_cmp_v_i;
  logic [AW-1:0]                    lw_cmp_rd_i;
  logic                             flush_i;
  logic [NUM_SRC-1:0][SEL_W-1:0]    fwd_sel_o;
  logic                             stall_o;
  logic                             lw_iss_rdy_o;
  logic [NREG-1:0]                  busy_o;
  logic [31:0]                      perf_stall_o;
  logic [1:0]                       err_o;

  modport master (
    output src_valid_i, src_used_i, src_addr_i, stg_valid_i, stg_wen_i, stg_rd_i, stg_ready_i,
           lw_iss_v_i, lw_iss_rd_i, lw_cmp_v_i, lw_cmp_rd_i, flush_i,
    input  fwd_sel_o, stall_o, lw_iss_rdy_o, busy_o, perf_stall_o, err_o
  );

  modport slave (
    input  src_valid_i, src_used_i, src_addr_i, stg_valid_i, stg_wen_i, stg_rd_i, stg_ready_i,
           lw_iss_v_i, lw_iss_rd_i, lw_cmp_v_i, lw_cmp_rd_i, flush_i,
    output fwd_sel_o, stall_o, lw_iss_rdy_o, busy_o, perf_stall_o, err_o
  );
endinterface

// File: rtl/ysyx_22040759_fwd_scoreboard_match.sv
// One operand's priority match: youngest producer stage wins, then the completion bus, else regfile.
module ysyx_22040759_fwd_match
  import ysyx_22040759_fwd_scoreboard_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int AW      = 5,
  parameter int SEL_W   = $clog2(NUM_FWD + 2)
) (
  input  logic                       used,
  input  logic [AW-1:0]              addr,
  input  logic [NUM_FWD-1:0]         stgValid,
  input  logic [NUM_FWD-1:0]         stgWen,
  input  logic [NUM_FWD-1:0][AW-1:0] stgRd,
  input  logic [NUM_FWD-1:0]         stgReady,
  input  logic                       cmpV,
  input  logic [AW-1:0]              cmpRd,
  input  logic                       busyBit,
  output logic [SEL_W-1:0]           sel,
  output logic                       hazard
);
  logic live, hit, hitRdy, cmpHit;

  always_comb begin
    sel    = SEL_W'(FWD_SEL_RF);
    hit    = 1'b0;
    hitRdy = 1'b1;
    live   = used & (addr != '0);
    cmpHit = cmpV & (cmpRd == addr);
    // Scan oldest to youngest so the youngest match is the one left standing.
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (stgValid[k] & stgWen[k] & (stgRd[k] != '0) & (stgRd[k] == addr)) begin
        hit    = 1'b1;
        hitRdy = stgReady[k];
        sel    = SEL_W'(k + 1);
      end
    end
    if (!hit && cmpHit) sel = SEL_W'(fwdSelLw(NUM_FWD));
    if (!live) sel = SEL_W'(FWD_SEL_RF);
    hazard = live & (hit ? !hitRdy : (busyBit & !cmpHit));
  end
endmodule

// File: rtl/ysyx_22040759_fwd_scoreboard.sv
// EX-stage forwarding + hazard unit: per-operand match, long-latency scoreboard, stall FSM, perf and error flags.
module ysyx_22040759_fwd_scoreboard
  import ysyx_22040759_fwd_scoreboard_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int NUM_FWD   = 3,
  parameter int AW        = 5,
  parameter int STALL_TMO = 64
) (
  input logic                        clock,
  input logic                        reset_n,
  ysyx_22040759_fwd_scoreboard_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_FWD + 2);
  localparam int NREG  = 2 ** AW;
  localparam int CW    = $clog2(STALL_TMO + 1);

  logic [NREG-1:0]               busyQ, busyN;
  logic [NUM_SRC-1:0]            opHaz;
  logic [NUM_SRC-1:0][SEL_W-1:0] selArr;
  logic                          h, stall, issRdy;
  fsmStateT                      state, stateN;
  logic [CW-1:0]                 consec;
  logic [31:0]                   perf;
  logic [1:0]                    err;

  for (genvar g = 0; g < NUM_SRC; g++) begin : gOp
    ysyx_22040759_fwd_match #(
      .NUM_FWD (NUM_FWD),
      .AW      (AW),
      .SEL_W   (SEL_W)
    ) uMatch (
      .used     (bus.src_used_i[g]),
      .addr     (bus.src_addr_i[g]),
      .stgValid (bus.stg_valid_i),
      .stgWen   (bus.stg_wen_i),
      .stgRd    (bus.stg_rd_i),
      .stgReady (bus.stg_ready_i),
      .cmpV     (bus.lw_cmp_v_i),
      .cmpRd    (bus.lw_cmp_rd_i),
      .busyBit  (busyQ[bus.src_addr_i[g]]),
      .sel      (selArr[g]),
      .hazard   (opHaz[g])
    );
  end

  assign h      = bus.src_valid_i & !bus.flush_i & (|opHaz);
  assign stall  = reset_n & h;
  assign issRdy = !busyQ[bus.lw_iss_rd_i] | (bus.lw_cmp_v_i & (bus.lw_cmp_rd_i == bus.lw_iss_rd_i));

  assign bus.fwd_sel_o    = selArr;
  assign bus.stall_o      = stall;
  assign bus.lw_iss_rdy_o = issRdy;
  assign bus.busy_o       = busyQ;
  assign bus.perf_stall_o = perf;
  assign bus.err_o        = err;

  // Clear before set so a same-rd issue+complete leaves the register owned.
  always_comb begin
    busyN = busyQ;
    if (bus.lw_cmp_v_i) busyN[bus.lw_cmp_rd_i] = 1'b0;
    if (bus.lw_iss_v_i && issRdy) busyN[bus.lw_iss_rd_i] = 1'b1;
    busyN[0] = 1'b0;
  end

  always_comb begin
    stateN = state;
    if (bus.flush_i) stateN = ST_RUN;
    else if (h)      stateN = ST_STALL;
    else             stateN = ST_RUN;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= stateN;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busyQ  <= '0;
      consec <= '0;
      perf   <= '0;
      err    <= '0;
    end else begin
      busyQ <= busyN;
      if (bus.lw_cmp_v_i && (bus.lw_cmp_rd_i != '0) && !busyQ[bus.lw_cmp_rd_i]) err[0] <= 1'b1;
      // h already folds in flush, so one test covers both clear conditions.
      if (h) begin
        if (consec != CW'(STALL_TMO)) consec <= consec + 1'b1;
        if (consec == CW'(STALL_TMO - 1)) err[1] <= 1'b1;
      end else begin
        consec <= '0;
      end
      if (stall) perf <= perf + 32'd1;
    end
  end
endmodule

// File: tb/tb_ysyx_22040759_fwd_scoreboard.sv
// Directed bench: combinational vector table for select/stall, plus hand sequences for multi-cycle behaviour.
module tb_ysyx_22040759_fwd_scoreboard;
  import ysyx_22040759_fwd_scoreboard_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  ysyx_22040759_fwd_scoreboard_if #(.NUM_SRC(2), .NUM_FWD(3), .AW(5)) bus ();

  ysyx_22040759_fwd_scoreboard #(
    .NUM_SRC(2), .NUM_FWD(3), .AW(5), .STALL_TMO(64)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string      name;
    logic       srcV;
    logic       flush;
    logic [1:0] used;
    logic [4:0] a0, a1;
    logic [2:0] stV, stW, stR;
    logic [4:0] rd0, rd1, rd2;
    logic       cmpV;
    logic [4:0] cmpRd;
    logic [2:0] eSel0, eSel1;
    logic       eStall;
  } vecT;

  vecT vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic clearAll();
    bus.src_valid_i = 1'b0; bus.src_used_i = '0; bus.src_addr_i = '0;
    bus.stg_valid_i = '0;   bus.stg_wen_i = '0;  bus.stg_rd_i = '0; bus.stg_ready_i = '1;
    bus.lw_iss_v_i = 1'b0;  bus.lw_iss_rd_i = '0;
    bus.lw_cmp_v_i = 1'b0;  bus.lw_cmp_rd_i = '0;
    bus.flush_i = 1'b0;
  endtask

  task automatic doReset();
    clearAll();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic applyVec(input vecT v);
    bus.src_valid_i = v.srcV;  bus.flush_i = v.flush;  bus.src_used_i = v.used;
    bus.src_addr_i[0] = v.a0;  bus.src_addr_i[1] = v.a1;
    bus.stg_valid_i = v.stV;   bus.stg_wen_i = v.stW;  bus.stg_ready_i = v.stR;
    bus.stg_rd_i[0] = v.rd0;   bus.stg_rd_i[1] = v.rd1; bus.stg_rd_i[2] = v.rd2;
    bus.lw_cmp_v_i = v.cmpV;   bus.lw_cmp_rd_i = v.cmpRd;
  endtask

  // Load-use hazard on operand 1: stage0 load to x7 not yet ready.
  task automatic setLoadUse();
    bus.src_valid_i = 1'b1; bus.src_used_i = 2'b10; bus.src_addr_i[1] = 5'd7;
    bus.stg_valid_i = 3'b001; bus.stg_wen_i = 3'b001; bus.stg_rd_i[0] = 5'd7; bus.stg_ready_i = 3'b110;
  endtask

  initial begin
    //          name        srcV fl  used   a0     a1     stV     stW     stR     rd0    rd1    rd2    cmpV cmpRd  sel0  sel1  stall
    vecs[0]  = '{"youngest", 1, 0, 2'b11, 5'd5,  5'd0,  3'b011, 3'b011, 3'b111, 5'd5,  5'd5,  5'd0,  0, 5'd0,  3'd1, 3'd0, 0};
    vecs[1]  = '{"kill_s0",  1, 0, 2'b11, 5'd5,  5'd0,  3'b010, 3'b011, 3'b111, 5'd5,  5'd5,  5'd0,  0, 5'd0,  3'd2, 3'd0, 0};
    vecs[2]  = '{"s0_nowen", 1, 0, 2'b01, 5'd5,  5'd0,  3'b101, 3'b100, 3'b111, 5'd5,  5'd0,  5'd5,  0, 5'd0,  3'd3, 3'd0, 0};
    vecs[3]  = '{"loaduse",  1, 0, 2'b10, 5'd0,  5'd7,  3'b001, 3'b001, 3'b110, 5'd7,  5'd0,  5'd0,  0, 5'd0,  3'd0, 3'd1, 1};
    vecs[4]  = '{"lu_noval", 0, 0, 2'b10, 5'd0,  5'd7,  3'b001, 3'b001, 3'b110, 5'd7,  5'd0,  5'd0,  0, 5'd0,  3'd0, 3'd1, 0};
    vecs[5]  = '{"lu_flush", 1, 1, 2'b10, 5'd0,  5'd7,  3'b001, 3'b001, 3'b110, 5'd7,  5'd0,  5'd0,  0, 5'd0,  3'd0, 3'd1, 0};
    vecs[6]  = '{"lu_unused",1, 0, 2'b00, 5'd0,  5'd7,  3'b001, 3'b001, 3'b110, 5'd7,  5'd0,  5'd0,  0, 5'd0,  3'd0, 3'd0, 0};
    vecs[7]  = '{"s0rdy_s1nr",1,0, 2'b10, 5'd0,  5'd7,  3'b011, 3'b011, 3'b101, 5'd7,  5'd7,  5'd0,  0, 5'd0,  3'd0, 3'd1, 0};
    vecs[8]  = '{"x0_rd",    1, 0, 2'b01, 5'd0,  5'd0,  3'b001, 3'b001, 3'b110, 5'd0,  5'd0,  5'd0,  0, 5'd0,  3'd0, 3'd0, 0};
    vecs[9]  = '{"cmpbus",   1, 0, 2'b01, 5'd12, 5'd0,  3'b000, 3'b000, 3'b111, 5'd0,  5'd0,  5'd0,  1, 5'd12, 3'd4, 3'd0, 0};
    vecs[10] = '{"stg_over_cmp",1,0,2'b01,5'd12, 5'd0,  3'b100, 3'b100, 3'b111, 5'd0,  5'd0,  5'd12, 1, 5'd12, 3'd3, 3'd0, 0};
    vecs[11] = '{"two_ops",  1, 0, 2'b11, 5'd3,  5'd4,  3'b110, 3'b110, 3'b111, 5'd0,  5'd3,  5'd4,  0, 5'd0,  3'd2, 3'd3, 0};

    // Reset: stall forced low even with a live hazard.
    clearAll();
    setLoadUse();
    #1 chk("rst_stall", bus.stall_o, 0);
    cyc(); cyc();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_perf", bus.perf_stall_o, 0);
    chk("rst_state", dut.state, ST_RUN);
    clearAll();
    reset_n = 1'b1;
    cyc();

    // Vectors live only between negedge and the next posedge so no state is disturbed.
    for (int i = 0; i < 12; i++) begin
      cyc();
      applyVec(vecs[i]);
      #1;
      chk({vecs[i].name, "_sel0"}, bus.fwd_sel_o[0], vecs[i].eSel0);
      chk({vecs[i].name, "_sel1"}, bus.fwd_sel_o[1], vecs[i].eSel1);
      chk({vecs[i].name, "_stall"}, bus.stall_o, vecs[i].eStall);
      #1 clearAll();
    end

    // Load-use: stall, FSM to STALL, then release.
    doReset();
    setLoadUse();
    #1 chk("lu_stall", bus.stall_o, 1);
    cyc();
    chk("lu_state_stall", dut.state, ST_STALL);
    chk("lu_perf1", bus.perf_stall_o, 1);
    bus.stg_ready_i = 3'b111;
    #1 chk("lu_rel_stall", bus.stall_o, 0);
    chk("lu_rel_sel1", bus.fwd_sel_o[1], 1);
    cyc();
    chk("lu_state_run", dut.state, ST_RUN);
    chk("lu_perf_hold", bus.perf_stall_o, 1);

    // Divide on x9: stall until completion, forward from completion bus.
    doReset();
    bus.lw_iss_v_i = 1'b1; bus.lw_iss_rd_i = 5'd9;
    #1 chk("div_issrdy", bus.lw_iss_rdy_o, 1);
    cyc();
    bus.lw_iss_v_i = 1'b0;
    chk("div_busy_set", bus.busy_o[9], 1);
    bus.src_valid_i = 1'b1; bus.src_used_i = 2'b01; bus.src_addr_i[0] = 5'd9;
    #1 chk("div_stall", bus.stall_o, 1);
    cyc(); cyc(); cyc();
    chk("div_perf3", bus.perf_stall_o, 3);
    bus.lw_cmp_v_i = 1'b1; bus.lw_cmp_rd_i = 5'd9;
    #1 chk("div_cmp_sel", bus.fwd_sel_o[0], 4);
    chk("div_cmp_stall", bus.stall_o, 0);
    cyc();
    clearAll();
    chk("div_busy_clr", bus.busy_o[9], 0);
    chk("div_perf_hold", bus.perf_stall_o, 3);
    chk("div_err", bus.err_o, 0);

    // Same-rd issue+complete keeps ownership; WAW issue blocked.
    doReset();
    bus.lw_iss_v_i = 1'b1; bus.lw_iss_rd_i = 5'd9;
    cyc();
    bus.lw_cmp_v_i = 1'b1; bus.lw_cmp_rd_i = 5'd9;
    #1 chk("ic_rdy", bus.lw_iss_rdy_o, 1);
    cyc();
    bus.lw_cmp_v_i = 1'b0;
    chk("ic_busy", bus.busy_o[9], 1);
    chk("ic_err", bus.err_o, 0);
    #1 chk("waw_rdy", bus.lw_iss_rdy_o, 0);
    cyc();
    clearAll();
    chk("waw_busy", bus.busy_o, 32'h0000_0200);

    // Spurious completion is sticky; x0 is never tracked or forwarded.
    doReset();
    bus.lw_cmp_v_i = 1'b1; bus.lw_cmp_rd_i = 5'd12;
    cyc();
    clearAll();
    chk("spur_err", bus.err_o, 2'b01);
    bus.lw_iss_v_i = 1'b1; bus.lw_iss_rd_i = 5'd0;
    cyc(); cyc();
    bus.lw_iss_v_i = 1'b0;
    chk("spur_err_sticky", bus.err_o, 2'b01);
    chk("x0_busy", bus.busy_o, 0);
    bus.src_valid_i = 1'b1; bus.src_used_i = 2'b11;
    bus.lw_cmp_v_i = 1'b1; bus.lw_cmp_rd_i = 5'd0;
    #1 chk("x0_sel", bus.fwd_sel_o, 0);
    chk("x0_stall", bus.stall_o, 0);
    doReset();
    chk("spur_err_rst", bus.err_o, 0);

    // Stall timeout after 64 consecutive cycles, then flush and reset.
    doReset();
    setLoadUse();
    for (int i = 0; i < 63; i++) cyc();
    chk("tmo_63", bus.err_o, 0);
    cyc();
    chk("tmo_64", bus.err_o, 2'b10);
    chk("tmo_perf", bus.perf_stall_o, 64);
    bus.flush_i = 1'b1;
    #1 chk("fl_stall", bus.stall_o, 0);
    chk("fl_state_now", dut.state, ST_STALL);
    cyc();
    chk("fl_state_run", dut.state, ST_RUN);
    chk("fl_perf", bus.perf_stall_o, 64);
    clearAll();
    cyc();
    chk("tmo_sticky", bus.err_o, 2'b10);
    reset_n = 1'b0;
    cyc();
    chk("fin_err", bus.err_o, 0);
    chk("fin_perf", bus.perf_stall_o, 0);
    chk("fin_state", dut.state, ST_RUN);
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
